// File: rtl/sng_stream_gen.sv
// ============================================================================
// Module      : sng_stream_gen
// Description : Stochastic number generator. Turns a binary operand into a
//               unipolar bitstream (bit = rnd < value) of programmable length.
//               Optional macro SNG_ONES_COUNT_EN adds a per-stream ones counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sng_stream_gen #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [LEN_W-1:0] in_len,
  input  logic [WIDTH-1:0] rnd,
  output logic             rnd_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             last,
  output logic             done,
  output logic             busy
`ifdef SNG_ONES_COUNT_EN
  ,
  output logic [LEN_W-1:0] ones_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] value_q;
  logic [LEN_W-1:0] remaining;
  logic             hit;

  assign hit = (rnd < value_q);

  // rnd_en is combinational so the LFSR steps in the same cycle its word is consumed.
  assign in_ready = (state == S_IDLE) && !rst;
  assign rnd_en   = (state == S_RUN);
  assign done     = (state == S_DONE);
  assign busy     = (state != S_IDLE);

`ifdef SNG_ONES_COUNT_EN
  logic [LEN_W-1:0] ones_q;
  assign ones_count = ones_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      value_q   <= '0;
      remaining <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      last      <= 1'b0;
`ifdef SNG_ONES_COUNT_EN
      ones_q    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          bit_out   <= 1'b0;
          bit_valid <= 1'b0;
          last      <= 1'b0;
          if (in_valid) begin
            value_q   <= in_value;
            remaining <= in_len;
`ifdef SNG_ONES_COUNT_EN
            ones_q    <= '0;
`endif
            state     <= (in_len != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          bit_out   <= hit;
          bit_valid <= 1'b1;
          remaining <= remaining - LEN_W'(1);
`ifdef SNG_ONES_COUNT_EN
          // Counted as the bit is registered so the total is final in the done cycle.
          if (hit) ones_q <= ones_q + LEN_W'(1);
`endif
          if (remaining == LEN_W'(1)) begin
            last  <= 1'b1;
            state <= S_DONE;
          end else begin
            last  <= 1'b0;
          end
        end
        S_DONE: begin
          bit_out   <= 1'b0;
          bit_valid <= 1'b0;
          last      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          bit_out   <= 1'b0;
          bit_valid <= 1'b0;
          last      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sng_stream_gen.sv
// ============================================================================
// Module      : tb_sng_stream_gen
// Description : Scoreboard bench for sng_stream_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sng_stream_gen;

  localparam int WIDTH = 16;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_value = '0;
  logic [LEN_W-1:0] in_len = '0;
  logic [WIDTH-1:0] rnd = '0;
  logic             in_ready, rnd_en, bit_out, bit_valid, last, done, busy;
`ifdef SNG_ONES_COUNT_EN
  logic [LEN_W-1:0] ones_count;
`endif

  sng_stream_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_len    (in_len),
    .rnd       (rnd),
    .rnd_en    (rnd_en),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .last      (last),
    .done      (done),
    .busy      (busy)
`ifdef SNG_ONES_COUNT_EN
    ,
    .ones_count(ones_count)
`endif
  );

  always #5 clk = ~clk;

  int         errors   = 0;
  int         checks   = 0;
  int         done_cnt = 0;
  int         exp_ones = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_e;
  logic [WIDTH-1:0] rnd_tab[16];
  bit         use_tab = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output side of the scoreboard: every bit_valid must match the oldest expected {bit,last}.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (bit_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("bit_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("bit_last", {30'd0, bit_out, last}, {30'd0, mon_e});
      end
    end
  end

  task automatic drive_stream(input logic [WIDTH-1:0] value, input logic [LEN_W-1:0] len);
    logic [WIDTH-1:0] r;
    logic             b;
    @(negedge clk);
    check_eq("ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_value = value;
    in_len   = len;
    exp_ones = 0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      r = use_tab ? rnd_tab[i] : WIDTH'($urandom_range(0, 65535));
      rnd = r;
      b = (r < value);
      if (b) exp_ones++;
      exp_q.push_back({b, (i == int'(len) - 1)});
      check_eq("rnd_en_run", {31'd0, rnd_en}, 32'd1);
      check_eq("done_run", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    check_eq("rnd_en_done", {31'd0, rnd_en}, 32'd0);
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    check_eq("busy_done", {31'd0, busy}, 32'd1);
    check_eq("ready_done", {31'd0, in_ready}, 32'd0);
`ifdef SNG_ONES_COUNT_EN
    check_eq("ones_done", 32'(ones_count), 32'(exp_ones));
`endif
    @(negedge clk);
    check_eq("done_clear", {31'd0, done}, 32'd0);
    check_eq("ready_after", {31'd0, in_ready}, 32'd1);
    check_eq("bv_after", {31'd0, bit_valid}, 32'd0);
`ifdef SNG_ONES_COUNT_EN
    check_eq("ones_stable", 32'(ones_count), 32'(exp_ones));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;
    int en_cnt;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] v;
    logic             b;
    bit               exp_en;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_outputs", {26'd0, bit_out, bit_valid, last, done, busy, rnd_en}, 32'd0);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_post_rst", {31'd0, in_ready}, 32'd1);
`ifdef SNG_ONES_COUNT_EN
    check_eq("ones_rst", 32'(ones_count), 32'd0);
`endif

    // T1: zero operand never produces a one
    use_tab = 1'b0;
    drive_stream(16'h0000, 16'd8);

    // T2: half-scale operand against boundary random words
    use_tab = 1'b1;
    rnd_tab[0] = 16'h0000; rnd_tab[1] = 16'hFFFF; rnd_tab[2] = 16'h7FFF; rnd_tab[3] = 16'h8000;
    drive_stream(16'h8000, 16'd4);
`ifdef SNG_ONES_COUNT_EN
    check_eq("t2_ones", 32'(ones_count), 32'd2);
`endif

    // T3: full-scale operand, strict compare against all-ones
    for (int i = 0; i < 16; i++) rnd_tab[i] = 16'hFFFF;
    drive_stream(16'hFFFF, 16'd3);

    // T4: zero-length stream
    drive_stream(16'h1234, 16'd0);

    // Random streams
    use_tab = 1'b0;
    drive_stream(16'h6000, 16'd12);
    drive_stream(16'hF000, 16'd1);

    // T5: reset in the middle of a stream
    @(negedge clk);
    check_eq("t5_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_value = 16'h4000; in_len = 16'd10;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r = WIDTH'($urandom_range(0, 65535));
      rnd = r;
      exp_q.push_back({(r < 16'h4000), 1'b0});
      @(negedge clk);
    end
    done_before = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_outputs", {26'd0, bit_out, bit_valid, last, done, busy, rnd_en}, 32'd0);
    check_eq("t5_ready_rst", {31'd0, in_ready}, 32'd0);
`ifdef SNG_ONES_COUNT_EN
    check_eq("t5_ones", 32'(ones_count), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_ready_after", {31'd0, in_ready}, 32'd1);
    check_eq("t5_no_done", 32'(done_cnt - done_before), 32'd0);
    check_eq("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // T6: in_valid held high across two streams (len 5 then 2)
    done_before = done_cnt;
    en_cnt = 0;
    @(negedge clk);
    check_eq("t6_ready0", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_value = 16'h3000; in_len = 16'd5;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      exp_en = ((c >= 1) && (c <= 5)) || (c == 8) || (c == 9);
      check_eq("t6_rnd_en", {31'd0, rnd_en}, {31'd0, exp_en});
      check_eq("t6_done", {31'd0, done}, {31'd0, (c == 6) || (c == 10)});
      check_eq("t6_ready", {31'd0, in_ready}, {31'd0, (c == 7) || (c == 11)});
      if (rnd_en === 1'b1) en_cnt++;
      if (exp_en) begin
        r = WIDTH'($urandom_range(0, 65535));
        rnd = r;
        v = (c <= 5) ? 16'h3000 : 16'hC000;
        b = (r < v);
        exp_q.push_back({b, (c == 5) || (c == 9)});
      end
      if (c == 1) begin
        in_value = 16'hC000;
        in_len   = 16'd2;
      end
      if (c == 8) in_valid = 1'b0;
    end
    check_eq("t6_en_total", 32'(en_cnt), 32'd7);
    check_eq("t6_done_cnt", 32'(done_cnt - done_before), 32'd2);

    repeat (2) @(negedge clk);
    check_eq("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
